// File: rtl/aes_pkg.sv
// Shared types and defaults for the AES-128 round controller.
package aes_pkg;

    localparam int NR_DEFAULT         = 10;
    localparam int KG_TIMEOUT_DEFAULT = 16;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        IDLE,
        KEY_GEN,
        READY,
        DEC_PREP,
        RUN,
        OUT
    } state_e;

    // Byte 0 is the most significant byte of the packed vector.
    typedef logic [0:15][7:0] key_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// AES-128 round controller: key load/expansion handshake, round sequencing
// and key-slot rotation for an iterative encrypt/decrypt datapath.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR         = NR_DEFAULT,
    parameter int KG_TIMEOUT = KG_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  key_t       key_in,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       blk_valid,
    input  logic       blk_mode,
    output logic       blk_ready,
    output logic       res_valid,
    input  logic       res_ready,
    output key_t       km_key,
    output logic       km_init_key,
    output logic       km_shift_enc,
    output logic       km_shift_dec,
    input  logic       km_ready_key,
    output logic       dp_load,
    output logic       dp_round_en,
    output logic [3:0] dp_round,
    output logic       dp_last,
    output logic       dp_mode,
    output logic       key_loaded,
    output logic       kg_err
);

    localparam int               KGW     = $clog2(KG_TIMEOUT + 1);
    localparam logic [KGW-1:0]   KG_LAST = KGW'(KG_TIMEOUT - 1);
    localparam logic [3:0]       NR4     = 4'(NR);

    state_e         state_q;
    key_t           km_key_q;
    logic           km_init_q;
    logic [KGW-1:0] kg_cnt_q;
    logic [3:0]     round_q;
    logic           mode_q;
    logic           loaded_q;
    logic           kg_err_q;

    logic key_xfer;
    logic blk_acc;
    logic in_run;

    assign key_ready = (state_q == IDLE) || (state_q == READY);
    assign blk_ready = (state_q == READY) && !key_valid;
    assign key_xfer  = key_valid && key_ready;
    assign blk_acc   = blk_valid && blk_ready;
    assign in_run    = (state_q == RUN);
    assign res_valid = (state_q == OUT);

    assign dp_round_en = in_run;
    assign dp_last     = in_run && (round_q == NR4);

    // Decrypt spends the accept cycle and DEC_PREP rewinding the key slot to
    // the last round key, so its initial AddRoundKey happens one cycle later.
    assign dp_load      = (blk_acc && (blk_mode == MODE_ENC)) || (state_q == DEC_PREP);
    assign km_shift_enc = (blk_acc && (blk_mode == MODE_ENC))
                        || (in_run && (mode_q == MODE_ENC));
    assign km_shift_dec = (blk_acc && (blk_mode == MODE_DEC))
                        || (state_q == DEC_PREP)
                        || (in_run && (mode_q == MODE_DEC) && (round_q != NR4));

    assign km_key      = km_key_q;
    assign km_init_key = km_init_q;
    assign dp_round    = round_q;
    assign dp_mode     = mode_q;
    assign key_loaded  = loaded_q;
    assign kg_err      = kg_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            km_key_q  <= '0;
            km_init_q <= 1'b0;
            kg_cnt_q  <= '0;
            round_q   <= '0;
            mode_q    <= 1'b0;
            loaded_q  <= 1'b0;
            kg_err_q  <= 1'b0;
        end else begin
            km_init_q <= 1'b0;
            kg_err_q  <= 1'b0;
            case (state_q)
                IDLE, READY: begin
                    if (key_xfer) begin
                        km_key_q  <= key_in;
                        km_init_q <= 1'b1;
                        loaded_q  <= 1'b0;
                        kg_cnt_q  <= '0;
                        state_q   <= KEY_GEN;
                    end else if (blk_acc) begin
                        mode_q <= blk_mode;
                        if (blk_mode == MODE_DEC) begin
                            state_q <= DEC_PREP;
                        end else begin
                            state_q <= RUN;
                            round_q <= 4'd1;
                        end
                    end
                end
                KEY_GEN: begin
                    if (km_ready_key) begin
                        loaded_q <= 1'b1;
                        kg_cnt_q <= '0;
                        state_q  <= READY;
                    end else if (kg_cnt_q == KG_LAST) begin
                        kg_err_q <= 1'b1;
                        kg_cnt_q <= '0;
                        state_q  <= IDLE;
                    end else begin
                        kg_cnt_q <= kg_cnt_q + KGW'(1);
                    end
                end
                DEC_PREP: begin
                    round_q <= 4'd1;
                    state_q <= RUN;
                end
                RUN: begin
                    if (round_q == NR4) begin
                        round_q <= '0;
                        state_q <= OUT;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                OUT: begin
                    if (res_ready) state_q <= READY;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl with behavioural key memory and AES datapath models.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int NR = 10;
    localparam int KG_TIMEOUT = 16;
    localparam key_t KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst;
    key_t key_in;
    logic key_valid, key_ready, blk_valid, blk_mode, blk_ready, res_valid, res_ready;
    key_t km_key;
    logic km_init_key, km_shift_enc, km_shift_dec, km_ready_key;
    logic dp_load, dp_round_en, dp_last, dp_mode, key_loaded, kg_err;
    logic [3:0] dp_round;

    int checks = 0;
    int failures = 0;

    logic [7:0] sbox [256];
    logic [7:0] isbox [256];
    logic [0:10][127:0] rk_q;
    int ptr_q, kg_age_q, kg_delay;
    bit hold_ready;
    logic [127:0] dp_state_q, blk_data;
    logic [127:0] sb_data [$];
    int sb_lat [$];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(NR), .KG_TIMEOUT(KG_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .blk_valid(blk_valid), .blk_mode(blk_mode), .blk_ready(blk_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .km_key(km_key), .km_init_key(km_init_key), .km_shift_enc(km_shift_enc),
        .km_shift_dec(km_shift_dec), .km_ready_key(km_ready_key),
        .dp_load(dp_load), .dp_round_en(dp_round_en), .dp_round(dp_round),
        .dp_last(dp_last), .dp_mode(dp_mode), .key_loaded(key_loaded), .kg_err(kg_err)
    );

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    function automatic logic [0:10][127:0] expand(input key_t k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        logic [0:10][127:0] r;
        for (int i = 0; i < 4; i++) w[i] = {k[4*i], k[4*i+1], k[4*i+2], k[4*i+3]};
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
        return r;
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c, input logic inv);
        logic [7:0] a [4];
        logic [7:0] m [4];
        logic [31:0] o;
        for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
        if (inv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        for (int r = 0; r < 4; r++)
            o[31-8*r -: 8] = gmul(m[0], a[r]) ^ gmul(m[1], a[(r+1)%4])
                           ^ gmul(m[2], a[(r+2)%4]) ^ gmul(m[3], a[(r+3)%4]);
        return o;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic dec, input logic last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (dec) b[r+4*((c+r)%4)] = isbox[a[r+4*c]];
                else     b[r+4*c] = sbox[a[r+4*((c+r)%4)]];
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        if (!dec && !last)
            for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mixcol(o[127-32*c -: 32], 1'b0);
        o = o ^ k;
        if (dec && !last)
            for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mixcol(o[127-32*c -: 32], 1'b1);
        return o;
    endfunction

    assign km_ready_key = !hold_ready && (kg_age_q == kg_delay);

    // Key memory (rotating slot pointer) and iterative datapath models.
    always @(posedge clk) begin
        if (rst) begin
            ptr_q    <= 0;
            kg_age_q <= 0;
        end else begin
            if (km_init_key) begin
                rk_q     <= expand(km_key);
                ptr_q    <= 0;
                kg_age_q <= 1;
            end else begin
                if (km_ready_key) kg_age_q <= 0;
                else if (kg_age_q > 0) kg_age_q <= kg_age_q + 1;
                if (km_shift_enc) ptr_q <= (ptr_q == NR) ? 0 : ptr_q + 1;
                else if (km_shift_dec) ptr_q <= (ptr_q == 0) ? NR : ptr_q - 1;
            end
            if (dp_load) dp_state_q <= blk_data ^ rk_q[ptr_q];
            else if (dp_round_en) dp_state_q <= aes_round(dp_state_q, rk_q[ptr_q], dp_mode, dp_last);
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({key_ready, blk_ready, res_valid, key_loaded, kg_err, km_init_key} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_hs got=%b exp=100000",
                     {key_ready, blk_ready, res_valid, key_loaded, kg_err, km_init_key});
        end
        checks++;
        if ({dp_load, dp_round_en, dp_round, dp_last, km_shift_enc, km_shift_dec} !== 9'b0) begin
            failures++;
            $display("FAIL reset_dp got=%b exp=0",
                     {dp_load, dp_round_en, dp_round, dp_last, km_shift_enc, km_shift_dec});
        end
        checks++;
        if (km_key !== key_t'(0)) begin
            failures++;
            $display("FAIL reset_km_key got=%h exp=0", km_key);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (key_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle_key_ready got=%b exp=1", key_ready);
        end
    endtask

    task automatic test_key_load(input key_t k);
        int n = 0;
        int inits = 1;
        int errs = 0;
        @(negedge clk);
        key_valid = 1'b1;
        key_in = k;
        #1;
        checks++;
        if (key_ready !== 1'b1) begin
            failures++;
            $display("FAIL key_ready got=%b exp=1", key_ready);
        end
        @(negedge clk);
        key_valid = 1'b0;
        #1;
        checks++;
        if ({km_init_key, key_loaded, key_ready} !== 3'b100) begin
            failures++;
            $display("FAIL keygen_entry got=%b exp=100", {km_init_key, key_loaded, key_ready});
        end
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            key_valid = (i >= 3 && i <= 5);
            key_in = ~k;
            #1;
            if (km_init_key) inits++;
            if (kg_err) errs++;
            if (key_loaded) n = i;
        end
        key_valid = 1'b0;
        checks++;
        if (n !== 12) begin
            failures++;
            $display("FAIL key_loaded_cycle got=%0d exp=12", n);
        end
        checks++;
        if (inits !== 1 || errs !== 0) begin
            failures++;
            $display("FAIL keygen_pulses got=init%0d/err%0d exp=init1/err0", inits, errs);
        end
        checks++;
        if (km_key !== k) begin
            failures++;
            $display("FAIL km_key_hold got=%h exp=%h", km_key, k);
        end
        checks++;
        if ({key_ready, blk_ready} !== 2'b11) begin
            failures++;
            $display("FAIL ready_state got=%b exp=11", {key_ready, blk_ready});
        end
    endtask

    task automatic test_block(input logic m, input logic [127:0] din, input logic [127:0] dexp,
                              input int hold);
        int lat = 0, n_enc = 0, n_dec = 0, loads = 0, load_at = -1;
        int rounds = 0, rnd_err = 0, both = 0, last_sh = 0, stuck = 0, r;
        int exp_lat;
        logic [127:0] exp_data;
        res_ready = (hold == 0);
        @(negedge clk);
        blk_valid = 1'b1;
        blk_mode = m;
        blk_data = din;
        #1;
        checks++;
        if (blk_ready !== 1'b1) begin
            failures++;
            $display("FAIL blk_ready got=%b exp=1", blk_ready);
        end
        sb_data.push_back(dexp);
        sb_lat.push_back(m ? NR + 2 : NR + 1);
        for (int k = 0; k <= 40 && lat == 0; k++) begin
            if (k > 0) begin
                @(negedge clk);
                blk_valid = 1'b0;
                #1;
            end
            if (km_shift_enc && km_shift_dec) both++;
            n_enc += int'(km_shift_enc);
            n_dec += int'(km_shift_dec);
            if (dp_load) begin
                loads++;
                load_at = k;
            end
            if (dp_round_en) begin
                rounds++;
                r = k - int'(m);
                if (dp_round !== 4'(r) || dp_last !== (r == NR)) rnd_err++;
                if (r == NR && km_shift_dec) last_sh++;
            end
            if (res_valid) lat = k;
        end
        exp_lat = sb_lat.pop_front();
        exp_data = sb_data.pop_front();
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL res_latency got=%0d exp=%0d", lat, exp_lat);
        end
        checks++;
        if (dp_state_q !== exp_data) begin
            failures++;
            $display("FAIL result_data got=%h exp=%h", dp_state_q, exp_data);
        end
        checks++;
        if (n_enc !== (m ? 0 : NR + 1) || n_dec !== (m ? NR + 1 : 0)) begin
            failures++;
            $display("FAIL shift_count got=enc%0d/dec%0d mode=%0d exp=%0d total", n_enc, n_dec, m, NR + 1);
        end
        checks++;
        if (loads !== 1 || load_at !== int'(m)) begin
            failures++;
            $display("FAIL dp_load got=n%0d@%0d exp=n1@%0d", loads, load_at, m);
        end
        checks++;
        if (rounds !== NR || rnd_err !== 0) begin
            failures++;
            $display("FAIL round_seq got=rounds%0d/err%0d exp=rounds%0d/err0", rounds, rnd_err, NR);
        end
        checks++;
        if (both !== 0 || last_sh !== 0) begin
            failures++;
            $display("FAIL shift_excl got=both%0d/last%0d exp=0/0", both, last_sh);
        end
        checks++;
        if (dp_mode !== m) begin
            failures++;
            $display("FAIL dp_mode got=%b exp=%b", dp_mode, m);
        end
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                #1;
                if (!res_valid || km_shift_enc || km_shift_dec) stuck++;
            end
            res_ready = 1'b1;
            checks++;
            if (stuck !== 0) begin
                failures++;
                $display("FAIL res_hold got=%0d bad cycles exp=0", stuck);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({res_valid, blk_ready} !== 2'b01) begin
            failures++;
            $display("FAIL out_to_ready got=%b exp=01", {res_valid, blk_ready});
        end
    endtask

    task automatic test_encrypt();
        test_block(MODE_ENC, PT, CT, 0);
    endtask

    task automatic test_decrypt();
        test_block(MODE_DEC, CT, PT, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            test_block(MODE_ENC, PT, CT, i);
            test_block(MODE_DEC, CT, PT, 2 - i);
        end
    endtask

    task automatic test_priority();
        int n = 0;
        @(negedge clk);
        key_valid = 1'b1;
        blk_valid = 1'b1;
        blk_mode = MODE_ENC;
        key_in = KEY;
        #1;
        checks++;
        if ({key_ready, blk_ready, dp_load, km_shift_enc, km_shift_dec} !== 5'b10000) begin
            failures++;
            $display("FAIL key_priority got=%b exp=10000",
                     {key_ready, blk_ready, dp_load, km_shift_enc, km_shift_dec});
        end
        @(negedge clk);
        key_valid = 1'b0;
        blk_valid = 1'b0;
        #1;
        checks++;
        if ({km_init_key, dp_round_en, dp_load} !== 3'b100) begin
            failures++;
            $display("FAIL priority_keygen got=%b exp=100", {km_init_key, dp_round_en, dp_load});
        end
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            #1;
            if (key_loaded) n = i;
        end
        checks++;
        if (n !== 12) begin
            failures++;
            $display("FAIL priority_reload got=%0d exp=12", n);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        hold_ready = 1'b1;
        @(negedge clk);
        key_valid = 1'b1;
        key_in = KEY;
        @(negedge clk);
        key_valid = 1'b0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            @(negedge clk);
            blk_valid = 1'b1;
            #1;
            if (kg_err) n = i;
        end
        checks++;
        if (n !== KG_TIMEOUT) begin
            failures++;
            $display("FAIL kg_timeout_cycle got=%0d exp=%0d", n, KG_TIMEOUT);
        end
        checks++;
        if ({key_loaded, key_ready, blk_ready, dp_load} !== 4'b0100) begin
            failures++;
            $display("FAIL kg_timeout_state got=%b exp=0100", {key_loaded, key_ready, blk_ready, dp_load});
        end
        @(negedge clk);
        #1;
        checks++;
        if (kg_err !== 1'b0) begin
            failures++;
            $display("FAIL kg_err_pulse got=%b exp=0", kg_err);
        end
        blk_valid = 1'b0;
        hold_ready = 1'b0;
        test_key_load(KEY);
    endtask

    task automatic test_rst_mid();
        bit seen = 1'b0;
        int rv = 0;
        @(negedge clk);
        blk_valid = 1'b1;
        blk_mode = MODE_ENC;
        blk_data = PT;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            blk_valid = 1'b0;
            #1;
            if (dp_round_en && dp_round == 4'd5) begin
                seen = 1'b1;
                rst = 1'b1;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rst_round5_reached got=0 exp=1");
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({key_ready, dp_round_en, res_valid, key_loaded, dp_round} !== 8'b10000000) begin
            failures++;
            $display("FAIL rst_mid_idle got=%b exp=10000000",
                     {key_ready, dp_round_en, res_valid, key_loaded, dp_round});
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (res_valid) rv++;
        end
        checks++;
        if (rv !== 0) begin
            failures++;
            $display("FAIL rst_mid_no_result got=%0d exp=0", rv);
        end
        test_key_load(KEY);
        test_encrypt();
    endtask

    initial begin
        logic [7:0] x, inv, s;
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            inv = 8'h00;
            if (x != 8'h00) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, x);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox[i] = s;
            isbox[s] = x;
        end
        rst = 1'b1;
        key_in = '0;
        key_valid = 1'b0;
        blk_valid = 1'b0;
        blk_mode = 1'b0;
        blk_data = '0;
        res_ready = 1'b1;
        hold_ready = 1'b0;
        kg_delay = 11;
        test_reset();
        test_key_load(KEY);
        test_encrypt();
        test_decrypt();
        test_back_to_back();
        test_priority();
        test_encrypt();
        test_timeout();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL provide parameter NR, default 10, number of AES-128 cipher rounds.
REQ-002 SHALL provide parameter KG_TIMEOUT, default 16, maximum cycles allowed in KEY_GEN before abort.
REQ-003 SHALL use clock clk and reset rst (synchronous, active-high), both 1-bit inputs.
REQ-004 key_in  in  8x[0:15]  cipher key bytes; key_valid in 1; key_ready out 1  (key load handshake).
REQ-005 blk_valid  in  1; blk_mode  in  1 (0 = encrypt, 1 = decrypt); blk_ready  out  1  (block start handshake).
REQ-006 res_valid  out  1; res_ready  in  1  (result handshake).
REQ-007 km_key  out  8x[0:15]  latched key to key memory; km_init_key  out  1; km_shift_enc  out  1; km_shift_dec  out  1; km_ready_key  in  1.
REQ-008 dp_load  out  1 (load block, AddRoundKey with slot 0); dp_round_en  out  1; dp_round  out  4; dp_last  out  1; dp_mode  out  1.
REQ-009 key_loaded  out  1 (valid schedule held); kg_err  out  1 (one-cycle timeout pulse).

Function
REQ-010 FSM states SHALL be IDLE, KEY_GEN, READY, DEC_PREP, RUN, OUT.
REQ-011 key_ready SHALL be 1 only in IDLE and READY; a transfer occurs when key_valid & key_ready at a clk edge.
REQ-012 On key transfer: latch key_in into km_key, enter KEY_GEN, drop key_loaded; km_key SHALL stay constant until the next key transfer.
REQ-013 km_init_key SHALL be 1 for exactly the first cycle in KEY_GEN.
REQ-014 KEY_GEN -> READY on the cycle after km_ready_key = 1; key_loaded SHALL be 1 from READY entry.
REQ-015 KEY_GEN cycle counter reaching KG_TIMEOUT without km_ready_key SHALL -> IDLE, pulse kg_err, leave key_loaded = 0.
REQ-016 blk_ready = (state == READY) & !key_valid; key load has priority over block start.
REQ-017 Encrypt accept cycle T: dp_load = 1, km_shift_enc = 1, -> RUN with dp_round = 1.
REQ-018 Decrypt accept cycle T: km_shift_dec = 1, dp_load = 0, -> DEC_PREP; DEC_PREP: dp_load = 1, km_shift_dec = 1, -> RUN with dp_round = 1.
REQ-019 RUN: dp_round_en = 1, dp_round increments 1..NR, one round per cycle, no stalls; dp_last = 1 when dp_round = NR.
REQ-020 RUN encrypt: km_shift_enc = 1 every round incl. NR; RUN decrypt: km_shift_dec = 1 for rounds 1..NR-1, 0 in round NR.
REQ-021 Each block SHALL issue exactly NR+1 shifts, returning key slot 0 to round key 0.
REQ-022 dp_mode SHALL hold blk_mode latched at accept until the next accept.
REQ-023 After round NR -> OUT; res_valid = 1 until res_ready; OUT -> READY on res_valid & res_ready.
REQ-024 Latency accept-to-res_valid: NR+1 cycles encrypt, NR+2 cycles decrypt.
REQ-025 km_shift_enc and km_shift_dec SHALL never both be 1, and SHALL be 0 in IDLE, KEY_GEN, READY (no accept), OUT.
REQ-026 key_valid outside IDLE/READY SHALL be ignored (not accepted) until READY.

Reset
REQ-027 On rst: state IDLE, km_key = 0, counters 0, all handshake/control outputs 0 except key_ready = 1 in the following IDLE cycle.
REQ-028 rst mid-block or mid-KEY_GEN SHALL abandon the operation without res_valid; key memory shares rst.

Structure
REQ-029 aes_pkg SHALL hold NR default, mode enum (MODE_ENC, MODE_DEC), controller state enum and the 16-byte key type.
REQ-030 No sub-module is needed; FSM, round counter and timeout counter live in aes_round_ctrl.

Verification
REQ-031 Key 000102..0f loaded, km_ready_key 11 cycles after init -> one init pulse, key_loaded = 1 next cycle, kg_err = 0.
REQ-032 Encrypt accept at T with res_ready = 1 -> dp_load at T, dp_round 1..10 at T+1..T+10, res_valid at T+11, 11 km_shift_enc pulses.
REQ-033 Decrypt accept -> DEC_PREP, dp_load at T+1, res_valid at T+12, 11 km_shift_dec pulses, none in round 10.
REQ-034 With key_mem and datapath, encrypt 00112233..ff -> 69c4e0d86a7b0430d8cdb78070b4c55a; decrypt -> original; repeat 3x with no reload.
REQ-035 km_ready_key held 0 -> kg_err pulse after 16 KEY_GEN cycles, IDLE, blk_ready = 0.
REQ-036 key_valid and blk_valid both 1 in READY -> key accepted, block not; rst asserted at round 5 -> IDLE next cycle, no res_valid.
